// File: rtl/blit_pixelwrite_if.sv
// blit_pixelwrite_if: pixel stream from the stepper plus the byte-masked word write port
interface blit_pixelwrite_if #(parameter int ADDR_WIDTH = 26);
   logic                  pix_valid;
   logic [15:0]           pix_x;
   logic [15:0]           pix_y;
   logic [7:0]            pix_colour;
   logic                  pix_last;
   logic                  stall;
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_wstrb;
   logic                  mem_ack;
   modport master (
      output pix_valid, pix_x, pix_y, pix_colour, pix_last, mem_ack,
      input  stall, mem_req, mem_addr, mem_wdata, mem_wstrb
   );
   modport slave (
      input  pix_valid, pix_x, pix_y, pix_colour, pix_last, mem_ack,
      output stall, mem_req, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/blit_pixelwrite.sv
// blit_pixelwrite: clips pixels, merges same-word bytes and issues masked word writes
module blit_pixelwrite #(parameter int ADDR_WIDTH = 26) (
   input  logic                   clock,
   input  logic                   resetn,
   blit_pixelwrite_if.slave       bus,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [15:0]            stride,
   input  logic signed [15:0]     clip_x1,
   input  logic signed [15:0]     clip_y1,
   input  logic signed [15:0]     clip_x2,
   input  logic signed [15:0]     clip_y2,
   output logic                   busy
);
   logic                  s1_valid, s1_last, s1_in_clip;
   logic [7:0]            s1_colour;
   logic [ADDR_WIDTH-1:0] s1_word;
   logic [1:0]            s1_lane;
   logic                  buf_valid, flush_pending, out_valid;
   logic [ADDR_WIDTH-1:0] buf_addr, out_addr;
   logic [31:0]           buf_data, out_data;
   logic [3:0]            buf_strb, out_strb;
   logic                  stall, in_clip, flush_go, take, bv, same, out_move, out_avail, to_out;
   logic [ADDR_WIDTH-1:0] pix_addr;
   logic [31:0]           m_data;
   logic [3:0]            m_strb;
   assign stall = out_valid & buf_valid;
   assign busy = s1_valid | buf_valid | out_valid | flush_pending;
   assign bus.stall = stall;
   assign bus.mem_req = out_valid;
   assign bus.mem_addr = out_addr;
   assign bus.mem_wdata = out_data;
   assign bus.mem_wstrb = out_strb;
   always_comb begin
      in_clip = $signed(bus.pix_x) >= clip_x1 && $signed(bus.pix_x) <= clip_x2 &&
                $signed(bus.pix_y) >= clip_y1 && $signed(bus.pix_y) <= clip_y2;
      pix_addr = base_addr + ADDR_WIDTH'(32'(bus.pix_y) * 32'(stride)) + ADDR_WIDTH'(bus.pix_x);
      // a flushed buffer is gone before the incoming pixel is considered
      flush_go = !stall && buf_valid && (flush_pending || (s1_valid && !s1_in_clip && s1_last));
      take = !stall && s1_valid && s1_in_clip;
      bv = buf_valid && !flush_go;
      same = bv && buf_addr == s1_word;
      out_move = flush_go || (take && bv && !same);
      out_avail = (!out_valid || bus.mem_ack) && !out_move;
      to_out = take && s1_last && out_avail;
      m_data = ((same ? buf_data : 32'd0) & ~(32'hFF << (8 * s1_lane))) | (32'(s1_colour) << (8 * s1_lane));
      m_strb = (same ? buf_strb : 4'd0) | (4'd1 << s1_lane);
   end
   always_ff @(posedge clock) begin
      if (!resetn) begin
         s1_valid <= 1'b0;
         s1_last <= 1'b0;
         s1_in_clip <= 1'b0;
         s1_colour <= '0;
         s1_word <= '0;
         s1_lane <= '0;
         buf_valid <= 1'b0;
         flush_pending <= 1'b0;
         buf_addr <= '0;
         buf_data <= '0;
         buf_strb <= '0;
         out_valid <= 1'b0;
         out_addr <= '0;
         out_data <= '0;
         out_strb <= '0;
      end else begin
         if (!stall) begin
            s1_valid <= bus.pix_valid;
            s1_last <= bus.pix_valid && bus.pix_last;
            s1_in_clip <= in_clip;
            s1_colour <= bus.pix_colour;
            s1_word <= in_clip ? {pix_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
            s1_lane <= in_clip ? pix_addr[1:0] : 2'd0;
         end
         if (take) begin
            buf_valid <= !to_out;
            flush_pending <= s1_last && !to_out;
            buf_addr <= s1_word;
            buf_data <= m_data;
            buf_strb <= m_strb;
         end else if (flush_go) begin
            buf_valid <= 1'b0;
            flush_pending <= 1'b0;
         end
         if (out_move) begin
            out_valid <= 1'b1;
            out_addr <= buf_addr;
            out_data <= buf_data;
            out_strb <= buf_strb;
         end else if (to_out) begin
            out_valid <= 1'b1;
            out_addr <= s1_word;
            out_data <= m_data;
            out_strb <= m_strb;
         end else if (bus.mem_ack) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/blit_pixelwrite.md
Name: blit_pixelwrite

Overview:
- Consumer end of the blitter coordinate stream. Accepts (x, y, colour) pixels from the line/rect stepper and clips them against a rectangle.
- Converts surviving pixels to byte addresses in an 8-bpp framebuffer. Pixels falling in the same 32-bit word are merged into one write.
- Issues byte-masked word writes on a req/ack memory port.
- Back-pressures the stepper through `stall`, which has the same meaning as the stepper's stall input: while high, the upstream holds its outputs.

Parameters:
- ADDR_WIDTH, 26, width of the byte address on the memory port.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- pix_valid  in  1  pixel present on pix_x/pix_y/pix_colour this cycle.
- pix_x  in  16  signed pixel X.
- pix_y  in  16  signed pixel Y.
- pix_colour  in  8  pixel value.
- pix_last  in  1  final pixel of the primitive; forces a flush. Meaningful with pix_valid only.
- stall  out  1  upstream must hold its pix_* signals this cycle.
- base_addr  in  ADDR_WIDTH  framebuffer byte address of (0,0), word aligned.
- stride  in  16  bytes per row (unsigned).
- clip_x1, clip_y1, clip_x2, clip_y2  in  16 each  signed, inclusive clip rectangle.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address; bits [1:0] are always 0.
- mem_wdata  out  32  write data; little-endian, lane 0 = [7:0].
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  write accepted.
- busy  out  1  pixel in flight or write pending.

Behaviour:
- Reset (resetn=0 at an edge):
  - s1_valid, buf_valid, flush_pending and out_valid clear.
  - mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, stall=0, busy=0.
  - Any pending write is abandoned; no mem_req is raised for it afterwards.
- Configuration (base_addr, stride, clip_*) must be stable while busy=1. Changing it while busy=1 is undefined.
- stall = out_valid & buf_valid, taken from registers. While stall=1, stage S1 and the buffer hold; only the output handshake advances.
- Stage S1 (registered when stall=0):
  - Captures pix_valid, pix_last, colour.
  - in_clip = clip_x1<=x<=clip_x2 and clip_y1<=y<=clip_y2. Comparisons are signed, so negative coordinates clip.
  - byte address = base_addr + y*stride + x. The product is unsigned 16x16, and the sum is truncated to ADDR_WIDTH. The address is computed only for in-clip pixels.
  - Splits the address into a word address (bits [1:0] zeroed) and a lane (bits [1:0]).
- Merge buffer: holds one word address, data and strb. It is updated when stall=0 and s1_valid. Cases:
  - Clipped pixel, not last: dropped.
  - Clipped pixel, last: the buffer (if valid) is marked for flush.
  - Buffer empty: load the pixel; strb = one-hot lane.
  - Same word: write the colour into the lane and set its strb bit. A repeated byte is overwritten by the later pixel.
  - Different word: the buffer moves to the output register (guaranteed free because stall=0), then the new pixel loads.
  - Last with out free: the merged result goes straight to the output register and the buffer clears.
  - Last but the buffer is displaced to output in the same edge: the new pixel loads and flush_pending=1. When out becomes free, the buffer moves to out and flush_pending clears.
- Output register:
  - out_valid drives mem_req.
  - mem_addr/mem_wdata/mem_wstrb are stable while mem_req=1.
  - mem_ack with mem_req=1 completes the write; out_valid clears at that edge. A new word may load at the same edge.
  - mem_ack while mem_req=0 is ignored.
  - Writes are issued in pixel order.
- Latency: a last, in-clip pixel with an empty pipeline, sampled at edge E0, raises mem_req after edge E1.
- busy = s1_valid | buf_valid | out_valid | flush_pending.

Test Plan:
1. Merge into one word:
   - Setup: base_addr=0x1000, stride=640, clip (0,0)-(639,479).
   - Stimulus: pixels (4,2)=0x0B, (5,2)=0x16, (6,2)=0x21, (7,2)=0x2C, last on the 4th; mem_ack high.
   - Required: exactly one write: addr 0x1504, wdata 0x2C21160B, wstrb 1111.
2. Word change:
   - Stimulus: (3,0)=0xAA, then (4,0)=0xBB last.
   - Required: write 0x1000 / 0xAA000000 / 1000, then 0x1004 / 0x000000BB / 0001, in that order.
3. Clipping:
   - Stimulus: (-1,0), (640,5), (10,480) last.
   - Required: mem_req never asserts; busy=0 within 3 cycles.
4. Backpressure:
   - Stimulus: 8 pixels spanning 4 distinct words; hold mem_ack low for 10 cycles, then high.
   - Required: stall asserts only while out_valid & buf_valid; pix_* held during stall is not lost or duplicated; 4 writes in order with correct strb.
5. Same-byte overwrite:
   - Stimulus: (0,0)=0x01, then (0,0)=0x02 last.
   - Required: single write at 0x1000, byte0=0x02, wstrb 0001.
6. Reset mid-write:
   - Stimulus: resetn=0 for 1 cycle while mem_req=1 and mem_ack=0.
   - Required: next cycle mem_req=0, stall=0, busy=0; no write after release.
